// File: rtl/core_csr_pkg.sv
// Shared definitions for the core CSR access path: funct3 codes, FSM encoding,
// and CSR addresses common to the initiator and the CSR register file.
package core_csr_pkg;

  localparam logic [2:0] CSR_RW  = 3'b001;
  localparam logic [2:0] CSR_RS  = 3'b010;
  localparam logic [2:0] CSR_RC  = 3'b011;
  localparam logic [2:0] CSR_RWI = 3'b101;
  localparam logic [2:0] CSR_RSI = 3'b110;
  localparam logic [2:0] CSR_RCI = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [11:0] MSTATUS  = 12'h300;
  localparam logic [11:0] MISA     = 12'h301;
  localparam logic [11:0] MIE      = 12'h304;
  localparam logic [11:0] MTVEC    = 12'h305;
  localparam logic [11:0] MSCRATCH = 12'h340;
  localparam logic [11:0] MEPC     = 12'h341;
  localparam logic [11:0] MCAUSE   = 12'h342;
  localparam logic [11:0] MTVAL    = 12'h343;
  localparam logic [11:0] MIP      = 12'h344;
  localparam logic [11:0] MHARTID  = 12'hF14;

  // Address bits [11:10] == 2'b11 mark a read-only CSR.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/core_csr_alu.sv
// Combinational Zicsr read-modify-write datapath: new value, write intent and
// illegal-instruction detection from the latched instruction and old CSR value.
module core_csr_alu
  import core_csr_pkg::*;
#(
  parameter bit CHECK_RO = 1'b1
) (
  input  logic [2:0]  funct3,
  input  logic [11:0] csr,
  input  logic [31:0] old,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  output logic [31:0] new_val,
  output logic        wr_intent,
  output logic        illegal
);

  logic [31:0] src;

  always_comb begin
    src = funct3[2] ? {27'b0, rs1_idx} : rs1_data;

    unique case (funct3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old | src;
      2'b11:   new_val = old & ~src;
      default: new_val = old;
    endcase

    // Set/clear with x0 or zimm==0 is a pure read and must not write.
    wr_intent = (funct3[1:0] == 2'b01) || (rs1_idx != '0);

    illegal = (funct3[1:0] == 2'b00) ||
              (CHECK_RO && wr_intent && csr_is_ro(csr));
  end

endmodule

// File: rtl/core_csr_access.sv
// Initiator side of the CSR register-file port: runs one Zicsr instruction at a
// time as READ -> WRITE -> RESP and returns the old value for rd writeback.
module core_csr_access
  import core_csr_pkg::*;
#(
  parameter bit CHECK_RO = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [11:0] REQ_CSR,
  input  logic [4:0]  REQ_RS1_IDX,
  input  logic [31:0] REQ_RS1_DATA,
  input  logic [4:0]  REQ_RD,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [4:0]  RSP_RD,
  output logic [31:0] RSP_DATA,
  output logic        RSP_ILLEGAL,
  output logic [11:0] CSR_ADDR,
  output logic [31:0] CSR_WDATA,
  output logic        CSR_WE,
  input  logic [31:0] CSR_RDATA
);

  logic [1:0]  state, state_nxt;
  logic [2:0]  funct3_q;
  logic [11:0] csr_q;
  logic [4:0]  rs1_idx_q;
  logic [31:0] rs1_data_q;
  logic [4:0]  rd_q;
  logic [31:0] old_q;

  logic [31:0] new_val;
  logic        wr_intent;
  logic        illegal;
  logic        accept;

  core_csr_alu #(
    .CHECK_RO (CHECK_RO)
  ) u_alu (
    .funct3    (funct3_q),
    .csr       (csr_q),
    .old       (old_q),
    .rs1_idx   (rs1_idx_q),
    .rs1_data  (rs1_data_q),
    .new_val   (new_val),
    .wr_intent (wr_intent),
    .illegal   (illegal)
  );

  assign accept = (state == ST_IDLE) && REQ_VALID && !FLUSH;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_READ;
      ST_READ:  state_nxt = FLUSH ? ST_IDLE : ST_WRITE;
      // A flushed WRITE still commits its write; only the response is dropped.
      ST_WRITE: state_nxt = FLUSH ? ST_IDLE : ST_RESP;
      ST_RESP:  if (FLUSH || RSP_READY) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      funct3_q   <= '0;
      csr_q      <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      rd_q       <= '0;
      old_q      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        funct3_q   <= REQ_FUNCT3;
        csr_q      <= REQ_CSR;
        rs1_idx_q  <= REQ_RS1_IDX;
        rs1_data_q <= REQ_RS1_DATA;
        rd_q       <= REQ_RD;
      end
      if (state == ST_READ) old_q <= CSR_RDATA;
    end
  end

  // Outputs decode from the asynchronously reset state, so reset drops CSR_WE at once.
  always_comb begin
    REQ_READY   = (state == ST_IDLE);
    CSR_ADDR    = (state == ST_READ || state == ST_WRITE) ? csr_q : '0;
    CSR_WE      = (state == ST_WRITE) && wr_intent && !illegal;
    CSR_WDATA   = CSR_WE ? new_val : '0;
    RSP_VALID   = (state == ST_RESP);
    RSP_RD      = RSP_VALID ? rd_q : '0;
    RSP_ILLEGAL = RSP_VALID && illegal;
    RSP_DATA    = (RSP_VALID && !illegal) ? old_q : '0;
  end

endmodule

// File: tb/tb_core_csr_access.sv
// Directed bench for core_csr_access with a small behavioural CSR file model.
module tb_core_csr_access;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        FLUSH;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  REQ_FUNCT3;
  logic [11:0] REQ_CSR;
  logic [4:0]  REQ_RS1_IDX;
  logic [31:0] REQ_RS1_DATA;
  logic [4:0]  REQ_RD;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [4:0]  RSP_RD;
  logic [31:0] RSP_DATA;
  logic        RSP_ILLEGAL;
  logic [11:0] CSR_ADDR;
  logic [31:0] CSR_WDATA;
  logic        CSR_WE;
  logic [31:0] CSR_RDATA;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  core_csr_access #(
    .CHECK_RO (1'b1)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .FLUSH        (FLUSH),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_FUNCT3   (REQ_FUNCT3),
    .REQ_CSR      (REQ_CSR),
    .REQ_RS1_IDX  (REQ_RS1_IDX),
    .REQ_RS1_DATA (REQ_RS1_DATA),
    .REQ_RD       (REQ_RD),
    .RSP_VALID    (RSP_VALID),
    .RSP_READY    (RSP_READY),
    .RSP_RD       (RSP_RD),
    .RSP_DATA     (RSP_DATA),
    .RSP_ILLEGAL  (RSP_ILLEGAL),
    .CSR_ADDR     (CSR_ADDR),
    .CSR_WDATA    (CSR_WDATA),
    .CSR_WE       (CSR_WE),
    .CSR_RDATA    (CSR_RDATA)
  );

  always #5 CLK = ~CLK;

  // CSR file model: mscratch, mie writable; mhartid reads 1 to expose illegal-read zeroing.
  logic        mdl_init;
  logic [31:0] m_mscratch;
  logic [31:0] m_mie;
  int unsigned we_count;

  always @(posedge CLK) begin
    if (mdl_init) begin
      m_mscratch <= 32'h0000_00F0;
      m_mie      <= 32'h0000_0888;
      we_count   <= 0;
    end else if (CSR_WE) begin
      we_count <= we_count + 1;
      case (CSR_ADDR)
        12'h340: m_mscratch <= CSR_WDATA;
        12'h304: m_mie      <= CSR_WDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (CSR_ADDR)
      12'h340: CSR_RDATA = m_mscratch;
      12'h304: CSR_RDATA = m_mie;
      12'hF14: CSR_RDATA = 32'h1;
      default: CSR_RDATA = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one request; returns #1 after the accept edge (DUT in READ).
  task automatic issue(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] idx,
                       input logic [31:0] data, input logic [4:0] rd);
    REQ_FUNCT3   = f3;
    REQ_CSR      = csr;
    REQ_RS1_IDX  = idx;
    REQ_RS1_DATA = data;
    REQ_RD       = rd;
    REQ_VALID    = 1'b1;
    tick();
    REQ_VALID    = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [11:0] csr,
                       input logic [4:0] idx, input logic [31:0] data, input logic [4:0] rd,
                       input logic exp_we, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rsp, input logic exp_ill);
    int unsigned wc0;
    wc0 = we_count;
    issue(f3, csr, idx, data, rd);
    chk({tag, ".c1_addr"}, {20'b0, CSR_ADDR}, {20'b0, csr});
    chk({tag, ".c1_we"}, {31'b0, CSR_WE}, 32'd0);
    chk({tag, ".c1_req_ready"}, {31'b0, REQ_READY}, 32'd0);
    tick();
    chk({tag, ".c2_addr"}, {20'b0, CSR_ADDR}, {20'b0, csr});
    chk({tag, ".c2_we"}, {31'b0, CSR_WE}, {31'b0, exp_we});
    chk({tag, ".c2_wdata"}, CSR_WDATA, exp_wdata);
    tick();
    chk({tag, ".c3_rsp_valid"}, {31'b0, RSP_VALID}, 32'd1);
    chk({tag, ".c3_rsp_data"}, RSP_DATA, exp_rsp);
    chk({tag, ".c3_rsp_rd"}, {27'b0, RSP_RD}, {27'b0, rd});
    chk({tag, ".c3_rsp_ill"}, {31'b0, RSP_ILLEGAL}, {31'b0, exp_ill});
    chk({tag, ".c3_addr"}, {20'b0, CSR_ADDR}, 32'd0);
    chk({tag, ".c3_we"}, {31'b0, CSR_WE}, 32'd0);
    chk({tag, ".we_count"}, we_count, wc0 + {31'b0, exp_we});
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk({tag, ".idle_req_ready"}, {31'b0, REQ_READY}, 32'd1);
    chk({tag, ".idle_rsp_valid"}, {31'b0, RSP_VALID}, 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; FLUSH = 1'b0; REQ_VALID = 1'b0; RSP_READY = 1'b0;
    REQ_FUNCT3 = '0; REQ_CSR = '0; REQ_RS1_IDX = '0; REQ_RS1_DATA = '0; REQ_RD = '0;
    mdl_init = 1'b1;
    tick();
    tick();

    chk("rst.req_ready", {31'b0, REQ_READY}, 32'd1);
    chk("rst.rsp_valid", {31'b0, RSP_VALID}, 32'd0);
    chk("rst.rsp_ill", {31'b0, RSP_ILLEGAL}, 32'd0);
    chk("rst.rsp_data", RSP_DATA, 32'd0);
    chk("rst.rsp_rd", {27'b0, RSP_RD}, 32'd0);
    chk("rst.csr_we", {31'b0, CSR_WE}, 32'd0);
    chk("rst.csr_addr", {20'b0, CSR_ADDR}, 32'd0);
    chk("rst.csr_wdata", CSR_WDATA, 32'd0);

    // Requests are ignored while reset is held.
    REQ_VALID = 1'b1; REQ_CSR = 12'h340; REQ_FUNCT3 = 3'b001;
    tick();
    REQ_VALID = 1'b0;
    chk("rst.no_accept", {20'b0, CSR_ADDR}, 32'd0);
    mdl_init = 1'b0;
    RST_N = 1'b1;
    tick();

    // CSRRW mscratch: 0xF0 -> 0x12345678, then restore 0xF0.
    do_op("rw1", 3'b001, 12'h340, 5'd1, 32'h1234_5678, 5'd5, 1'b1, 32'h1234_5678, 32'h0000_00F0, 1'b0);
    chk("rw1.model", m_mscratch, 32'h1234_5678);
    do_op("rw2", 3'b001, 12'h340, 5'd2, 32'h0000_00F0, 5'd6, 1'b1, 32'h0000_00F0, 32'h1234_5678, 1'b0);

    // CSRRS with x0 is a pure read; with 0x0F sets bits to 0xFF.
    do_op("rs0", 3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd7, 1'b0, 32'h0, 32'h0000_00F0, 1'b0);
    do_op("rs3", 3'b010, 12'h340, 5'd3, 32'h0000_000F, 5'd8, 1'b1, 32'h0000_00FF, 32'h0000_00F0, 1'b0);
    chk("rs3.model", m_mscratch, 32'h0000_00FF);

    // CSRRCI mie, zimm=8: 0x888 & ~0x8 = 0x880; rs1_data must be ignored.
    do_op("rci", 3'b111, 12'h304, 5'h08, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h0000_0880, 32'h0000_0888, 1'b0);
    chk("rci.model", m_mie, 32'h0000_0880);

    // CSRRSI with zimm=0x11 on mie: 0x880 | 0x11 = 0x891.
    do_op("rsi", 3'b110, 12'h304, 5'h11, 32'h0, 5'd11, 1'b1, 32'h0000_0891, 32'h0000_0880, 1'b0);

    // Write to read-only mhartid and reserved funct3 are illegal with no write.
    do_op("ro", 3'b001, 12'hF14, 5'd1, 32'hDEAD_BEEF, 5'd12, 1'b0, 32'h0, 32'h0, 1'b1);
    do_op("ro_read", 3'b010, 12'hF14, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 32'h1, 1'b0);
    do_op("f3_100", 3'b100, 12'h340, 5'd1, 32'h5555_5555, 5'd14, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("f3_100.model", m_mscratch, 32'h0000_00FF);

    // Response backpressure: outputs stable, no second accept.
    issue(3'b010, 12'h340, 5'd0, 32'h0, 5'd9);
    tick();
    tick();
    REQ_VALID = 1'b1; REQ_FUNCT3 = 3'b001; REQ_CSR = 12'h304; REQ_RD = 5'd2;
    for (int i = 0; i < 5; i++) begin
      chk("hold.rsp_valid", {31'b0, RSP_VALID}, 32'd1);
      chk("hold.rsp_data", RSP_DATA, 32'h0000_00FF);
      chk("hold.rsp_rd", {27'b0, RSP_RD}, 32'd9);
      chk("hold.req_ready", {31'b0, REQ_READY}, 32'd0);
      tick();
    end
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk("hold.rel_req_ready", {31'b0, REQ_READY}, 32'd1);
    chk("hold.rel_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
    tick();
    chk("hold.no_accept", {20'b0, CSR_ADDR}, 32'd0);

    // FLUSH on the request cycle blocks acceptance.
    REQ_FUNCT3 = 3'b001; REQ_CSR = 12'h340; REQ_RS1_DATA = 32'h1; REQ_VALID = 1'b1; FLUSH = 1'b1;
    tick();
    REQ_VALID = 1'b0; FLUSH = 1'b0;
    chk("flush_acc.req_ready", {31'b0, REQ_READY}, 32'd1);
    chk("flush_acc.addr", {20'b0, CSR_ADDR}, 32'd0);

    // FLUSH in READ: no write, no response.
    issue(3'b001, 12'h340, 5'd1, 32'hAAAA_AAAA, 5'd3);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush_rd.we", {31'b0, CSR_WE}, 32'd0);
    chk("flush_rd.req_ready", {31'b0, REQ_READY}, 32'd1);
    tick();
    chk("flush_rd.rsp_valid", {31'b0, RSP_VALID}, 32'd0);
    chk("flush_rd.model", m_mscratch, 32'h0000_00FF);

    // FLUSH in WRITE: write commits, response dropped.
    issue(3'b001, 12'h340, 5'd1, 32'h0000_0055, 5'd3);
    tick();
    FLUSH = 1'b1;
    chk("flush_wr.we", {31'b0, CSR_WE}, 32'd1);
    tick();
    FLUSH = 1'b0;
    chk("flush_wr.model", m_mscratch, 32'h0000_0055);
    chk("flush_wr.req_ready", {31'b0, REQ_READY}, 32'd1);
    chk("flush_wr.rsp_valid", {31'b0, RSP_VALID}, 32'd0);

    // FLUSH in RESP: response dropped.
    issue(3'b010, 12'h340, 5'd0, 32'h0, 5'd4);
    tick();
    tick();
    chk("flush_rsp.pre_valid", {31'b0, RSP_VALID}, 32'd1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush_rsp.rsp_valid", {31'b0, RSP_VALID}, 32'd0);
    chk("flush_rsp.req_ready", {31'b0, REQ_READY}, 32'd1);

    // Reset during WRITE: CSR_WE drops immediately, model untouched.
    issue(3'b001, 12'h340, 5'd1, 32'h0000_0077, 5'd3);
    tick();
    chk("rst_wr.pre_we", {31'b0, CSR_WE}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rst_wr.we", {31'b0, CSR_WE}, 32'd0);
    chk("rst_wr.addr", {20'b0, CSR_ADDR}, 32'd0);
    chk("rst_wr.wdata", CSR_WDATA, 32'd0);
    tick();
    chk("rst_wr.model", m_mscratch, 32'h0000_0055);
    chk("rst_wr.rsp_valid", {31'b0, RSP_VALID}, 32'd0);
    RST_N = 1'b1;
    tick();
    chk("rst_wr.req_ready", {31'b0, REQ_READY}, 32'd1);

    // Normal operation after reset.
    do_op("post_rst", 3'b011, 12'h340, 5'd1, 32'h0000_0005, 5'd15, 1'b1, 32'h0000_0050, 32'h0000_0055, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_csr_access.md
Name: core_csr_access

Overview:
- Initiator side of the core CSR register-file port (CSR_ADDR / CSR_WDATA / CSR_WE / CSR_RDATA).
- Executes Zicsr instructions (CSRRW/S/C and their immediate forms) issued by decode as an atomic read-modify-write.
- Returns the old CSR value for writeback to rd.
- Sits between the decode/execute stage and the CSR register file; one instruction in flight.

Parameters:
- CHECK_RO, 1, when 1 a write-intent access to a read-only CSR (addr[11:10]==2'b11) is flagged illegal and suppressed.

Ports:
- CLK  input  1  clock; all state on rising edge
- RST_N  input  1  reset, asynchronous assert, active-low
- FLUSH  input  1  pipeline flush; abort the in-flight access
- REQ_VALID  input  1  request valid
- REQ_READY  output  1  request accepted when VALID & READY
- REQ_FUNCT3  input  3  instr[14:12]; 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- REQ_CSR  input  12  CSR address, instr[31:20]
- REQ_RS1_IDX  input  5  instr[19:15]; rs1 index, or zimm for the immediate forms
- REQ_RS1_DATA  input  32  rs1 register value (ignored for immediate forms)
- REQ_RD  input  5  destination register index
- RSP_VALID  output  1  response valid
- RSP_READY  input  1  response consumed when VALID & READY
- RSP_RD  output  5  latched rd
- RSP_DATA  output  32  old CSR value; 0 if illegal
- RSP_ILLEGAL  output  1  illegal-instruction indication
- CSR_ADDR  output  12  to the CSR file
- CSR_WDATA  output  32  to the CSR file
- CSR_WE  output  1  to the CSR file; write commits on the CLK edge
- CSR_RDATA  input  32  combinational read data from the CSR file

Behaviour:
- One clock, CLK. Reset is RST_N: asynchronous, active-low.
- Reset state is IDLE. Reset output values:
  - RSP_VALID=0, RSP_ILLEGAL=0, RSP_DATA=0, RSP_RD=0
  - CSR_WE=0, CSR_ADDR=0, CSR_WDATA=0
  - REQ_READY=1, a decode of IDLE; requests are not accepted while RST_N is low.
- Reset asserted mid-operation drops everything immediately, including deasserting CSR_WE combinationally. No partial write occurs after reset is asserted.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: REQ_READY=1. On REQ_VALID, latch funct3, csr, rs1_idx, rs1_data and rd, then go to READ. If FLUSH is high in the same cycle, nothing is accepted.
- READ (cycle 1 after accept):
  - Drive CSR_ADDR = csr and register CSR_RDATA into old.
  - Operand src = zero-extended rs1_idx for immediate forms (funct3[2]=1), else rs1_data.
  - New value: RW gives src; RS gives old|src; RC gives old&~src.
  - Write intent: RW/RWI always; RS/RC/RSI/RCI only when rs1_idx != 0.
  - Illegal when funct3 is 000 or 100, or when CHECK_RO=1 with write intent and csr[11:10]==2'b11.
  - Next state is WRITE.
- WRITE (cycle 2):
  - CSR_ADDR is held.
  - CSR_WE=1 only when there is write intent and the access is legal.
  - CSR_WDATA = new value; it is driven 0 when CSR_WE=0.
  - Next state is RESP.
- RESP (cycle 3 onward):
  - RSP_VALID=1, with RSP_DATA = old (0 if illegal), RSP_RD and RSP_ILLEGAL.
  - These outputs are held stable while RSP_READY=0.
  - On RSP_READY, go to IDLE.
- Latency: accept edge to RSP_VALID is 3 cycles. Throughput is one instruction per 4 cycles minimum. REQ_READY=0 in all states except IDLE.
- CSR_ADDR returns to 0 outside READ/WRITE. CSR_WE is high for exactly one cycle per legal write.
- FLUSH handling:
  - In READ: go to IDLE; no write, no response.
  - In WRITE: the write commits at this edge (side effects are architectural); the response is dropped and the next state is IDLE.
  - In RESP: the response is dropped and the next state is IDLE.
- All arithmetic is 32-bit bitwise; zimm is zero-extended to 32 bits.

Decomposition:
- Package core_csr_pkg holds:
  - funct3 localparams (CSR_RW=3'b001 … CSR_RCI=3'b111)
  - FSM state encoding
  - CSR address constants shared with the CSR file (MSTATUS=12'h300, MIE=12'h304, MSCRATCH=12'h340, MHARTID=12'hF14, …)
- One combinational sub-module, core_csr_alu. Inputs: funct3, old, rs1_idx, rs1_data. Outputs: new value, write intent, illegal.

Test Plan:
- CSRRW 0x340, rs1_data=0x12345678, rd=5, CSR model mscratch=0x000000F0 -> cycle1 CSR_ADDR=0x340; cycle2 CSR_WE=1, CSR_WDATA=0x12345678; cycle3 RSP_VALID=1, RSP_DATA=0xF0, RSP_RD=5, RSP_ILLEGAL=0.
- CSRRS 0x340, rs1_idx=0 -> CSR_WE never asserted, RSP_DATA=old. Then CSRRS 0x340, rs1_idx=3, rs1_data=0x0F, old=0xF0 -> CSR_WDATA=0xFF.
- CSRRCI 0x304, zimm=5'h08, mie=0x888 -> CSR_WDATA=0x880, RSP_DATA=0x888.
- CSRRW 0xF14 -> no CSR_WE, RSP_ILLEGAL=1, RSP_DATA=0. funct3=3'b100 -> RSP_ILLEGAL=1, no write.
- Hold RSP_READY=0 for 5 cycles -> RSP_VALID, RSP_DATA and RSP_RD stable, REQ_READY=0, no second accept. Release -> IDLE next cycle, REQ_READY=1.
- Three abort cases:
  - FLUSH in READ -> no write, no RSP_VALID, IDLE next.
  - FLUSH in WRITE -> write observed in the CSR model, no response.
  - RST_N low during WRITE -> CSR_WE drops at once and the CSR model is unchanged.
